// File: rtl/sum_acc_pkg.sv
// sum_acc_pkg: shared state type, default sizes and counter-width helper for sum_accumulator
package sum_acc_pkg;
  typedef enum logic {ST_ACCUM, ST_HOLD} state_t;
  localparam int SUM_IN_W  = 5;
  localparam int SUM_ACC_W = 8;
  localparam int SUM_COUNT = 4;
  function automatic int acc_cnt_w(input int count);
    return (count <= 2) ? 1 : $clog2(count);
  endfunction
endpackage

// File: rtl/sum_accumulator.sv
// sum_accumulator: sums COUNT accepted adder results and presents the total with a sticky overflow flag
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int IN_W  = SUM_IN_W,
  parameter int ACC_W = SUM_ACC_W,
  parameter int COUNT = SUM_COUNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);
  localparam int CW = acc_cnt_w(COUNT);
  localparam int SW = ACC_W + 1;
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);
  state_t state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, rdy_q;
  logic [ACC_W:0] sum;
  logic last;
  assign sum       = {1'b0, acc_q} + SW'(in_sum);
  assign last      = cnt_q == LAST;
  assign in_ready  = rdy_q & (state_q == ST_ACCUM) & ~clear;
  assign out_valid = state_q == ST_HOLD;
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;
  // next state: clear beats the output transfer, which beats an input accept
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = ST_ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (out_valid && out_ready) begin
      state_d = ST_ACCUM;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end else if (in_valid && in_ready) begin
      acc_d   = sum[ACC_W-1:0];
      ovf_d   = ovf_q | sum[ACC_W];
      cnt_d   = last ? '0 : cnt_q + 1'b1;
      state_d = last ? ST_HOLD : ST_ACCUM;
    end
  end
  // state registers; rdy_q holds off in_ready until the first clock after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      rdy_q   <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: directed checks of sum_accumulator, with a 6-bit instance for overflow
module tb_sum_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic [4:0] in_sum = '0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, out_ovf;
  logic [7:0] out_acc;
  logic in_ready6, out_valid6, out_ovf6;
  logic [5:0] out_acc6;
  int checks = 0;
  int errors = 0;
  int xfers = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (out_valid && out_ready) xfers++;

  sum_accumulator dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_ovf(out_ovf)
  );

  sum_accumulator #(.ACC_W(6)) dut6 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready6),
    .in_sum(in_sum), .out_valid(out_valid6), .out_ready(out_ready), .out_acc(out_acc6), .out_ovf(out_ovf6)
  );

  task automatic feed(input logic [4:0] v);
    @(negedge clk);
    in_valid = 1'b1;
    in_sum   = v;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_sum   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    checks++; if (out_acc !== 8'd0) begin errors++; $display("FAIL reset_acc: got %0d want 0", out_acc); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", out_ovf); end
    checks++; if (in_ready !== 1'b0 || in_ready6 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b/%0b want 0/0", in_ready, in_ready6); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ready_before_clk: got %0b want 0", in_ready); end
    @(negedge clk);
    #1;
    checks++; if (in_ready !== 1'b1 || in_ready6 !== 1'b1) begin errors++; $display("FAIL ready_after_clk: got %0b/%0b want 1/1", in_ready, in_ready6); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    feed(17);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %0b want 1", in_ready); end
    feed(16);
    feed(15);
    feed(14);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %0b want 0", out_valid); end
    idle();
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b want 1", out_valid); end
    checks++; if (out_acc !== 8'd62) begin errors++; $display("FAIL basic_acc: got %0d want 62", out_acc); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %0b want 0", out_ovf); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_hold_ready: got %0b want 0", in_ready); end
    idle();
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_one_cycle: got valid %0b ready %0b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_overflow();
    out_ready = 1'b1;
    repeat (4) feed(30);
    idle();
    #1;
    checks++; if (out_valid6 !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %0b want 1", out_valid6); end
    checks++; if (out_acc6 !== 6'd56) begin errors++; $display("FAIL ovf_acc: got %0d want 56", out_acc6); end
    checks++; if (out_ovf6 !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b want 1", out_ovf6); end
    checks++; if (out_acc !== 8'd120 || out_ovf !== 1'b0) begin errors++; $display("FAIL ovf_wide: got %0d/%0b want 120/0", out_acc, out_ovf); end
    repeat (4) feed(1);
    idle();
    #1;
    checks++; if (out_acc6 !== 6'd4) begin errors++; $display("FAIL ovf_next_acc: got %0d want 4", out_acc6); end
    checks++; if (out_ovf6 !== 1'b0) begin errors++; $display("FAIL ovf_sticky_clear: got %0b want 0", out_ovf6); end
    idle();
  endtask

  task automatic test_backpressure();
    int x0;
    out_ready = 1'b0;
    feed(10); idle(); feed(7); idle(); idle(); feed(3); feed(9);
    idle();
    #1;
    x0 = xfers;
    checks++; if (out_valid !== 1'b1 || out_acc !== 8'd29) begin errors++; $display("FAIL bp_result: got valid %0b acc %0d want 1 29", out_valid, out_acc); end
    for (int i = 0; i < 4; i++) begin
      feed(31);
      #1;
      checks++; if (out_valid !== 1'b1 || out_acc !== 8'd29 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold%0d: got valid %0b acc %0d ready %0b want 1 29 0", i, out_valid, out_acc, in_ready); end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b1 || out_acc !== 8'd29 || xfers != x0) begin errors++; $display("FAIL bp_before_xfer: got valid %0b acc %0d xfers %0d want 1 29 %0d", out_valid, out_acc, xfers, x0); end
    idle();
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || xfers != x0 + 1) begin errors++; $display("FAIL bp_after_xfer: got valid %0b ready %0b xfers %0d want 0 1 %0d", out_valid, in_ready, xfers, x0 + 1); end
    checks++; if (out_acc !== 8'd0) begin errors++; $display("FAIL bp_acc_zero: got %0d want 0", out_acc); end
  endtask

  task automatic test_clear_accum();
    out_ready = 1'b1;
    feed(5); feed(6);
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; in_sum = 20;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clr_ready: got %0b want 0", in_ready); end
    feed(1);
    clear = 1'b0;
    feed(2); feed(3); feed(4);
    idle();
    #1;
    checks++; if (out_valid !== 1'b1 || out_acc !== 8'd10) begin errors++; $display("FAIL clr_result: got valid %0b acc %0d want 1 10", out_valid, out_acc); end
    idle();
  endtask

  task automatic test_clear_hold();
    int x0;
    out_ready = 1'b0;
    feed(17); feed(16); feed(15); feed(14);
    idle();
    #1;
    checks++; if (out_valid !== 1'b1 || out_acc !== 8'd62) begin errors++; $display("FAIL ch_held: got valid %0b acc %0d want 1 62", out_valid, out_acc); end
    x0 = xfers;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_acc !== 8'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL ch_dropped: got valid %0b acc %0d ready %0b want 0 0 1", out_valid, out_acc, in_ready); end
    feed(17); feed(16); feed(15); feed(14);
    idle();
    #1;
    checks++; if (out_valid !== 1'b1 || out_acc !== 8'd62) begin errors++; $display("FAIL rh_held: got valid %0b acc %0d want 1 62", out_valid, out_acc); end
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_acc !== 8'd0 || in_ready !== 1'b0) begin errors++; $display("FAIL rh_async: got valid %0b acc %0d ready %0b want 0 0 0", out_valid, out_acc, in_ready); end
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rh_after: got valid %0b ready %0b want 0 1", out_valid, in_ready); end
    checks++; if (xfers != x0) begin errors++; $display("FAIL ch_no_xfer: got %0d want %0d", xfers, x0); end
  endtask

  task automatic test_integration();
    int exp_acc = 0;
    int k = 0;
    out_ready = 1'b1;
    for (int a = 7; a <= 10; a++) begin
      for (int b = 0; b <= 6; b++) begin
        feed(5'(a + b));
        exp_acc += a + b;
        k++;
        if (k % 4 == 0) begin
          idle();
          #1;
          checks++; if (out_valid !== 1'b1 || out_acc !== 8'(exp_acc) || out_ovf !== 1'b0) begin errors++; $display("FAIL int_group%0d: got valid %0b acc %0d ovf %0b want 1 %0d 0", k / 4, out_valid, out_acc, out_ovf, exp_acc); end
          exp_acc = 0;
        end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_clear_accum();
    test_clear_hold();
    test_integration();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
